// File: rtl/vector_stream_checker_pkg.sv
// Shared definitions for the output-bit vector stream checker: state encoding,
// word-count helper and default vector/word widths.
package vector_stream_checker_pkg;

  localparam int DEFAULT_VEC_W  = 1894;
  localparam int DEFAULT_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2
  } state_e;

  function automatic int calc_nwords(input int vec_w, input int word_w);
    return (vec_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/vector_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vector_stream_checker.sv
// Assembles a wide test vector from a word stream, holds it on vec_o while the
// external circuit settles, then compares its output bit against the expected bit.
module vector_stream_checker
  import vector_stream_checker_pkg::*;
#(
  parameter int VEC_W      = DEFAULT_VEC_W,
  parameter int WORD_W     = DEFAULT_WORD_W,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [VEC_W-1:0]  vec_o,
  input  logic              dut_bit_i,
  output logic [CNT_W-1:0]  total_o,
  output logic [CNT_W-1:0]  mism_o,
  output logic [CNT_W-1:0]  first_idx_o,
  output logic              err_o
);

  localparam int NWORDS = calc_nwords(VEC_W, WORD_W);
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               exp_q, exp_d;
  logic [3:0]         settle_q, settle_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               err_q, err_d;
  logic               inc_total, inc_mism;
  logic [CNT_W-1:0]   total_w, mism_w;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    exp_d     = exp_q;
    settle_d  = settle_q;
    first_d   = first_q;
    err_d     = err_q;
    inc_total = 1'b0;
    inc_mism  = 1'b0;

    if (clear_i) begin
      // Clear wins over everything, including a compare; vec_o is intentionally kept.
      state_d = ST_LOAD;
      idx_d   = '0;
      first_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (s_valid_i) begin
            for (int k = 0; k < NWORDS; k++) begin
              if (idx_q == IDX_W'(k)) begin
                for (int j = 0; j < WORD_W; j++) begin
                  if (k * WORD_W + j < VEC_W) vec_d[k * WORD_W + j] = s_data_i[j];
                end
              end
            end
            if (idx_q == IDX_W'(NWORDS - 1)) begin
              exp_d    = s_data_i[WORD_W-1];
              idx_d    = '0;
              settle_d = 4'(SETTLE_CYC);
              state_d  = ST_SETTLE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q <= 4'd1) state_d = ST_COMPARE;
          else                  settle_d = settle_q - 4'd1;
        end
        ST_COMPARE: begin
          inc_total = 1'b1;
          if (dut_bit_i != exp_q) begin
            inc_mism = 1'b1;
            if (!err_q) begin
              first_d = total_w;
              err_d   = 1'b1;
            end
          end
          state_d = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // NOTE: the vector register is reset too, so the checked circuit sees a known input after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      vec_q    <= '0;
      exp_q    <= 1'b0;
      settle_q <= '0;
      first_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear_i),
    .inc_i (inc_total),
    .cnt_o (total_w)
  );

  sat_counter #(.W(CNT_W)) u_mism_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear_i),
    .inc_i (inc_mism),
    .cnt_o (mism_w)
  );

  assign s_ready_o   = (state_q == ST_LOAD);
  assign vec_o       = vec_q;
  assign total_o     = total_w;
  assign mism_o      = mism_w;
  assign first_idx_o = first_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_vector_stream_checker.sv
// Directed bench with a scoreboard queue; a second instance with 4-bit counters
// shares all inputs to exercise saturation.
module tb_vector_stream_checker;

  localparam int VEC_W  = 1894;
  localparam int WORD_W = 32;
  localparam int SETTLE = 2;
  localparam int NW     = 60;

  typedef enum {M_NORMAL, M_STALL, M_CLEAR, M_RST} mode_e;

  typedef struct {
    logic [VEC_W-1:0] vec;
    logic             exp;
    logic             got;
  } item_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_i;
  logic              s_valid_i;
  logic [WORD_W-1:0] s_data_i;
  logic              dut_bit_i;

  logic              s_ready_o;
  logic [VEC_W-1:0]  vec_o;
  logic [31:0]       total_o, mism_o, first_idx_o;
  logic              err_o;

  logic              s_ready_s;
  logic [VEC_W-1:0]  vec_s;
  logic [3:0]        total_s, mism_s, first_s;
  logic              err_s;

  int checks = 0;
  int errors = 0;
  item_t sb[$];

  int model_total, model_mism, model_first;
  logic model_err;

  always #5 clk = ~clk;

  vector_stream_checker dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .vec_o       (vec_o),
    .dut_bit_i   (dut_bit_i),
    .total_o     (total_o),
    .mism_o      (mism_o),
    .first_idx_o (first_idx_o),
    .err_o       (err_o)
  );

  vector_stream_checker #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_s),
    .vec_o       (vec_s),
    .dut_bit_i   (dut_bit_i),
    .total_o     (total_s),
    .mism_o      (mism_s),
    .first_idx_o (first_s),
    .err_o       (err_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input logic [VEC_W-1:0] v, input logic e, input int k);
    logic [WORD_W-1:0] w;
    w = WORD_W'($urandom());
    for (int j = 0; j < WORD_W; j++)
      if (k * WORD_W + j < VEC_W) w[j] = v[k * WORD_W + j];
    if (k == NW - 1) w[WORD_W-1] = e;
    return w;
  endfunction

  task automatic model_zero();
    model_total = 0;
    model_mism  = 0;
    model_first = 0;
    model_err   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".total"}, total_o, model_total);
    check({tag, ".mism"},  mism_o,  model_mism);
    check({tag, ".first"}, first_idx_o, model_first);
    check({tag, ".err"},   err_o,   model_err);
    check({tag, ".total_sat"}, total_s, sat15(model_total));
    check({tag, ".mism_sat"},  mism_s,  sat15(model_mism));
    check({tag, ".first_sat"}, first_s, sat15(model_first));
    check({tag, ".err_sat"},   err_s,   model_err);
    check({tag, ".ready"},     s_ready_o, 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_zero();
    check_outputs("clear_pulse");
  endtask

  task automatic send_vector(input string tag, input logic [VEC_W-1:0] v,
                             input logic e, input logic got, input mode_e mode);
    item_t it;
    int    low;
    int    pre;
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      s_valid_i = 1'b1;
      s_data_i  = mk_word(v, e, k);
      if (k == NW - 1) begin
        dut_bit_i = got;
        sb.push_back('{vec: v, exp: e, got: got});
      end
      if (mode == M_STALL && k == 30) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          s_valid_i = 1'b0;
          s_data_i  = WORD_W'($urandom());
        end
        check({tag, ".stall_hold"}, $countones(vec_o[959:0] ^ v[959:0]), 0);
        check({tag, ".stall_ready"}, s_ready_o, 1);
      end
    end

    low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s_valid_i = 1'b0;
      clear_i   = 1'b0;
      rst       = 1'b0;
      if (s_ready_o) break;
      low++;
      if (mode == M_RST && low == 1) begin
        rst = 1'b1;
        #1;
        check({tag, ".rst_total"}, total_o, 0);
        check({tag, ".rst_vec_ones"}, $countones(vec_o), 0);
        check({tag, ".rst_ready"}, s_ready_o, 1);
      end
      if (mode == M_CLEAR && low == SETTLE + 1) clear_i = 1'b1;
    end

    check({tag, ".sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    it = sb.pop_front();

    if (mode == M_RST || mode == M_CLEAR) begin
      model_zero();
    end else begin
      check({tag, ".ready_low_cycles"}, low, SETTLE + 1);
      check({tag, ".vec_diff"}, $countones(vec_o ^ it.vec), 0);
      pre = model_total;
      model_total++;
      if (it.got !== it.exp) begin
        model_mism++;
        if (!model_err) begin
          model_first = pre;
          model_err   = 1'b1;
        end
      end
    end
    if (mode == M_CLEAR) check({tag, ".clear_vec_kept"}, $countones(vec_o ^ it.vec), 0);
    check_outputs(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [VEC_W-1:0] v;
    logic e;

    rst = 1'b1; clear_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; dut_bit_i = 1'b0;
    model_zero();
    repeat (3) @(negedge clk);
    check("reset.ready_in_rst", s_ready_o, 1);
    check("reset.vec_ones", $countones(vec_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset");

    // Single matching vector with only bit 81 set.
    v = '0;
    v[81] = 1'b1;
    send_vector("s1", v, 1'b1, 1'b1, M_NORMAL);
    check("s1.vec81", vec_o[81], 1);
    check("s1.total", total_o, 1);
    check("s1.mism", mism_o, 0);
    check("s1.err", err_o, 0);

    // Vectors 0..4, with 2 and 4 mismatching.
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      v = rand_vec();
      e = 1'($urandom_range(0, 1));
      send_vector("s2", v, e, (i == 2 || i == 4) ? ~e : e, M_NORMAL);
    end
    check("s2.total", total_o, 5);
    check("s2.mism", mism_o, 2);
    check("s2.first", first_idx_o, 2);
    check("s2.err", err_o, 1);

    // Stall after word 30.
    v = rand_vec();
    send_vector("s3", v, 1'b0, 1'b0, M_STALL);
    check("s3.total", total_o, 6);

    // Reset while settling, then a fresh vector.
    send_vector("s5_rst", rand_vec(), 1'b1, 1'b1, M_RST);
    v = rand_vec();
    send_vector("s5_fresh", v, 1'b1, 1'b1, M_NORMAL);
    check("s5.total", total_o, 1);

    // Clear coinciding with a mismatching compare.
    send_vector("s4", rand_vec(), 1'b1, 1'b0, M_CLEAR);
    check("s4.total", total_o, 0);
    check("s4.mism", mism_o, 0);
    check("s4.err", err_o, 0);

    // Twenty mismatching vectors saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      e = 1'($urandom_range(0, 1));
      send_vector("s6", rand_vec(), e, ~e, M_NORMAL);
    end
    check("s6.total_sat", total_s, 15);
    check("s6.mism_sat", mism_s, 15);
    check("s6.first_sat", first_s, 0);
    check("s6.total", total_o, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
